nand_phy_seq: RTL and testbench
===============================

NAND_PHY_SEQ -- requirements
Module: nand_phy_seq

Interface
REQ-001 Parameter NUM_CE, default 2: number of NAND targets (chip enables), range 1..8.
REQ-002 Parameter DW, default 8: NAND data bus width, 8 or 16.
REQ-003 Parameter TW, default 4: timing-config field width.
REQ-004 Parameter TOW, default 20: ready/busy timeout counter width.
REQ-005 Port clk, in, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst, in, 1: reset, asynchronous and active-high.
REQ-007 Ports cfg_twp, cfg_twh, cfg_trp, cfg_treh, in, TW each: pulse-width counts for nwe low, nwe high, nre low and nre high (a value of 0 is treated as 1).
REQ-008 Port cfg_timeout, in, TOW: ready/busy wait limit in cycles.
REQ-009 Ports op_valid in 1, op_ready out 1: operation handshake; an op is accepted when both are 1.
REQ-010 Port op_type, in, 3: operation code (0 CMD, 1 ADDR, 2 WR, 3 RD, 4 WAIT_RB); codes 5-7 are NOP.
REQ-011 Ports op_ce in clog2(NUM_CE) (minimum 1), op_data in DW, op_last in 1: target select, write byte/word, and release CE after this op.
REQ-012 Ports rd_valid out 1, rd_data out DW: read result, one-cycle valid pulse.
REQ-013 Ports busy out 1, timeout_err out 1, err_clr in 1: not-idle flag, sticky timeout flag, and its clear.
REQ-014 Port wp_en, in, 1: write protect request.
REQ-015 Ports nand_nce out NUM_CE, nand_cle, nand_ale, nand_nwe, nand_nre, nand_nwp out 1 each: NAND control signals, all registered.
REQ-016 Ports nand_dq_o out DW, nand_dq_oe out 1, nand_dq_i in DW: split data bus; the tristate buffer is placed at the top level.
REQ-017 Port nand_rnb, in, NUM_CE: per-target ready/busy#, asynchronous to clk.

Function
REQ-018 FSM states: IDLE, CE_GAP, WLO, WHI, RLO, RHI, RBW; op_ready = (state==IDLE); busy = !op_ready.
REQ-019 Accept cycle = cycle 0; registered outputs change at cycle 1.
REQ-020 CMD/ADDR/WR timing:
- WLO for twp cycles with nwe=0.
- WHI for twh cycles with nwe=1.
- Throughout WLO and WHI: cle=(CMD), ale=(ADDR), dq_oe=1, dq_o=op_data.
- op_ready returns at cycle twp+twh+1; cle, ale and dq_oe drop in the same cycle.
REQ-021 RD timing:
- RLO for trp cycles with nre=0.
- On the RLO->RHI transition, capture nand_dq_i into rd_data and pulse rd_valid for 1 cycle.
- RHI for treh cycles with nre=1; dq_oe=0 throughout.
REQ-022 WAIT_RB:
- RBW ignores rnb for the first 4 cycles (tWB).
- RBW then completes on the first cycle the synchronised nand_rnb[op_ce]==1.
- If cfg_timeout cycles elapse in RBW first: set timeout_err and return to IDLE.
REQ-023 CE hold: nand_nce[op_ce]=0 from cycle 1 of the op. After the op it stays 0 if op_last=0; it goes to 1 when returning to IDLE if op_last=1.
REQ-024 CE switch: if an op is accepted with op_ce different from the currently held CE, insert one CE_GAP cycle (all nce=1) before the op's first bus phase.
REQ-025 op_ce >= NUM_CE: the op is consumed with normal timing but no nce bit asserts. NOP codes complete in 1 cycle with no bus activity.
REQ-026 nand_nwp = registered ~wp_en, updated every cycle independent of the FSM.
REQ-027 nand_rnb is passed through 2-flop synchronisers; this adds 2 cycles of latency to RBW completion.
REQ-028 timeout_err: err_clr clears it. If a set and a clear occur in the same cycle, set wins.
REQ-029 Pulse counters are loaded with max(cfg,1) on state entry; cfg changes mid-op do not affect the current phase.

Reset
REQ-030 While rst=1, regardless of state:
- nce all 1; nwe=1, nre=1, cle=0, ale=0.
- dq_oe=0, dq_o=0, nwp=0.
- rd_valid=0, rd_data=0, timeout_err=0.
- state=IDLE, op_ready=1, synchronisers=0.
REQ-031 Reset mid-operation aborts the op with no completion or rd_valid; the op is not replayed.

Structure
REQ-032 Package nand_seq_pkg holds the op_type codes, the state enum and TWB_CYC=4.
REQ-033 Sub-module nand_rnb_sync: NUM_CE-wide 2-flop synchroniser with asynchronous active-high reset.

Verification
REQ-034 CMD 0x70 on CE0, twp=2, twh=1, op_last=0 -> nwe low at cycles 1-2 with cle=1 and dq_o=0x70; op_ready at cycle 4; nce[0] stays 0.
REQ-035 RD with trp=3, treh=2, nand_dq_i=0xA5 -> rd_valid pulses once with rd_data=0xA5 at cycle 4; op_ready at cycle 6.
REQ-036 WAIT_RB on CE1, rnb[1] rising 10 cycles after accept, timeout=100 -> completes 2-3 cycles after the rise; timeout_err stays 0.
REQ-037 WAIT_RB with rnb held 0 and timeout=50 -> timeout_err=1 and return to IDLE; err_clr pulse -> 0.
REQ-038 CMD on CE0 with op_last=0, then ADDR on CE1 -> one cycle with nce=2'b11 between the ops, then nce=2'b01.
REQ-039 rst asserted during WLO -> nwe=1, nce all 1 and dq_oe=0 immediately; op_ready=1 after release.

Source files
------------

// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND PHY sequencer: operation codes, FSM state
// encoding and the fixed tWB guard interval.
// No ports; imported by nand_phy_seq.
package nand_seq_pkg;

  // Operation codes carried on op_type; 5..7 are accepted as no-ops.
  localparam logic [2:0] OP_CMD  = 3'd0;
  localparam logic [2:0] OP_ADDR = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  // Cycles after entering the ready/busy wait during which rnb is ignored,
  // covering the device's WE#-high-to-busy delay.
  localparam int TWB_CYC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CE_GAP,
    ST_WLO,
    ST_WHI,
    ST_RLO,
    ST_RHI,
    ST_RBW
  } state_t;

  // Codes that actually drive the bus (everything except the no-ops).
  function automatic logic is_bus_op(input logic [2:0] t);
    return t <= OP_WAIT;
  endfunction

  // First bus phase an operation enters.
  function automatic state_t first_phase(input logic [2:0] t);
    if (t == OP_RD)   return ST_RLO;
    if (t == OP_WAIT) return ST_RBW;
    return ST_WLO;
  endfunction

endpackage

// File: rtl/nand_rnb_sync.sv
// Two-flop synchroniser for the per-target ready/busy# lines.
// Ports: clk, rst (async active-high), async_in[N] from the pads,
// sync_out[N] usable in the clk domain two cycles later.
module nand_rnb_sync #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] async_in,
  output logic [N-1:0] sync_out
);

  logic [N-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/nand_phy_seq.sv
// NAND flash PHY sequencer: turns CMD/ADDR/WR/RD/WAIT_RB operations into
// timed CE#/CLE/ALE/WE#/RE# waveforms with programmable pulse widths.
// Ports: cfg_* timing, op_* handshake in, rd_* result out, busy/timeout_err
// status, wp_en, nand_* pad-side signals (split data bus, all registered).
module nand_phy_seq
  import nand_seq_pkg::*;
#(
  parameter int NUM_CE = 2,
  parameter int DW     = 8,
  parameter int TW     = 4,
  parameter int TOW    = 20,
  localparam int CEW   = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TW-1:0]     cfg_twp,
  input  logic [TW-1:0]     cfg_twh,
  input  logic [TW-1:0]     cfg_trp,
  input  logic [TW-1:0]     cfg_treh,
  input  logic [TOW-1:0]    cfg_timeout,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_type,
  input  logic [CEW-1:0]    op_ce,
  input  logic [DW-1:0]     op_data,
  input  logic              op_last,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  input  logic              wp_en,
  output logic [NUM_CE-1:0] nand_nce,
  output logic              nand_cle,
  output logic              nand_ale,
  output logic              nand_nwe,
  output logic              nand_nre,
  output logic              nand_nwp,
  output logic [DW-1:0]     nand_dq_o,
  output logic              nand_dq_oe,
  input  logic [DW-1:0]     nand_dq_i,
  input  logic [NUM_CE-1:0] nand_rnb
);

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [TW-1:0] pw(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  // Selects at or above NUM_CE address no target.
  function automatic logic ce_in_range(input logic [CEW-1:0] c);
    return {1'b0, c} < (CEW+1)'(NUM_CE);
  endfunction

  state_t state, state_nxt;

  // Latched operation fields, valid from cycle 1 of the op.
  logic [2:0]     cur_type;
  logic [CEW-1:0] cur_ce;
  logic [DW-1:0]  cur_data;
  logic           cur_last;

  logic [TW-1:0]  cnt;   // remaining cycles in the current pulse phase
  logic [TOW-1:0] tcnt;  // cycles already spent in RBW

  // Target whose CE# is currently held low between ops.
  logic           ce_vld, ce_vld_nxt;
  logic [CEW-1:0] ce_sel, ce_sel_nxt;

  logic [NUM_CE-1:0] rnb_sync;

  logic accept, need_gap, rnb_sel, rbw_ready, rbw_tmo, tmo_set, rd_cap;
  logic [2:0]        eff_type;
  logic [DW-1:0]     eff_data;
  logic              wr_phase;
  logic [NUM_CE-1:0] nce_nxt;

  nand_rnb_sync #(.N(NUM_CE)) u_rnb_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (nand_rnb),
    .sync_out (rnb_sync)
  );

  assign op_ready = (state == ST_IDLE);
  assign busy     = ~op_ready;
  assign accept   = op_valid && op_ready;

  // Switching to a different target needs one cycle with every CE# high.
  assign need_gap = ce_vld && (op_ce != ce_sel);

  // An out-of-range target has no rnb line; treat it as ready so the op
  // still completes after the guard interval.
  assign rnb_sel   = ce_in_range(cur_ce) ? rnb_sync[cur_ce] : 1'b1;
  assign rbw_ready = (tcnt >= TOW'(TWB_CYC)) && rnb_sel;
  assign rbw_tmo   = ({1'b0, tcnt} + 1'b1) >= {1'b0, cfg_timeout};
  assign tmo_set   = (state == ST_RBW) && !rbw_ready && rbw_tmo;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (op_valid && is_bus_op(op_type))
          state_nxt = need_gap ? ST_CE_GAP : first_phase(op_type);
      end
      ST_CE_GAP: state_nxt = first_phase(cur_type);
      ST_WLO:    if (cnt <= TW'(1)) state_nxt = ST_WHI;
      ST_WHI:    if (cnt <= TW'(1)) state_nxt = ST_IDLE;
      ST_RLO:    if (cnt <= TW'(1)) state_nxt = ST_RHI;
      ST_RHI:    if (cnt <= TW'(1)) state_nxt = ST_IDLE;
      ST_RBW:    if (rbw_ready || rbw_tmo) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------- next outputs
  // Outputs are derived from the state being entered so that the pads
  // change on the same edge as the state register.
  always_comb begin
    eff_type   = accept ? op_type : cur_type;
    eff_data   = accept ? op_data : cur_data;
    ce_vld_nxt = ce_vld;
    ce_sel_nxt = ce_sel;
    if (accept && is_bus_op(op_type)) begin
      ce_vld_nxt = 1'b1;
      ce_sel_nxt = op_ce;
    end
    if ((state != ST_IDLE) && (state_nxt == ST_IDLE) && cur_last)
      ce_vld_nxt = 1'b0;

    nce_nxt = '1;
    if (ce_vld_nxt && (state_nxt != ST_CE_GAP) && ce_in_range(ce_sel_nxt))
      nce_nxt[ce_sel_nxt] = 1'b0;

    wr_phase = (state_nxt == ST_WLO) || (state_nxt == ST_WHI);
    // Data is sampled at the end of the RE# low phase.
    rd_cap   = (state == ST_RLO) && (state_nxt == ST_RHI);
  end

  // ---------------------------------------------------- datapath / timers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_type <= '0;
      cur_ce   <= '0;
      cur_data <= '0;
      cur_last <= 1'b0;
      cnt      <= '0;
      tcnt     <= '0;
      ce_vld   <= 1'b0;
      ce_sel   <= '0;
    end else begin
      if (accept) begin
        cur_type <= op_type;
        cur_ce   <= op_ce;
        cur_data <= op_data;
        cur_last <= op_last;
      end
      // Widths are sampled only on phase entry, so a cfg change mid-phase
      // takes effect from the next phase.
      if (state_nxt != state) begin
        unique case (state_nxt)
          ST_WLO:  cnt <= pw(cfg_twp);
          ST_WHI:  cnt <= pw(cfg_twh);
          ST_RLO:  cnt <= pw(cfg_trp);
          ST_RHI:  cnt <= pw(cfg_treh);
          default: cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      tcnt   <= ((state == ST_RBW) && (state_nxt == ST_RBW)) ? tcnt + 1'b1 : '0;
      ce_vld <= ce_vld_nxt;
      ce_sel <= ce_sel_nxt;
    end
  end

  // ------------------------------------------------------ output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nand_nce    <= '1;
      nand_cle    <= 1'b0;
      nand_ale    <= 1'b0;
      nand_nwe    <= 1'b1;
      nand_nre    <= 1'b1;
      nand_dq_o   <= '0;
      nand_dq_oe  <= 1'b0;
      nand_nwp    <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      nand_nce    <= nce_nxt;
      nand_cle    <= wr_phase && (eff_type == OP_CMD);
      nand_ale    <= wr_phase && (eff_type == OP_ADDR);
      nand_nwe    <= (state_nxt != ST_WLO);
      nand_nre    <= (state_nxt != ST_RLO);
      nand_dq_o   <= wr_phase ? eff_data : '0;
      nand_dq_oe  <= wr_phase;
      nand_nwp    <= ~wp_en;
      rd_valid    <= rd_cap;
      if (rd_cap) rd_data <= nand_dq_i;
      // A timeout in the same cycle as a clear leaves the flag set.
      if (tmo_set)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_phy_seq.sv
// Self-checking bench for nand_phy_seq: directed vector table, hand-written
// reset / cfg / error-flag sequences, then randomized ops against a model.
// Ports: none (top-level bench).
module tb_nand_phy_seq;
  localparam int NUM_CE = 2;
  localparam int DW     = 8;
  localparam int TW     = 4;
  localparam int TOW    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [TW-1:0]  cfg_twp = 1, cfg_twh = 1, cfg_trp = 1, cfg_treh = 1;
  logic [TOW-1:0] cfg_timeout = 10;
  logic op_valid = 0, op_ready, op_last = 0;
  logic [2:0] op_type = 0;
  logic [0:0] op_ce = 0;
  logic [DW-1:0] op_data = 0, rd_data, nand_dq_o, nand_dq_i = 0;
  logic rd_valid, busy, timeout_err, err_clr = 0, wp_en = 0;
  logic [NUM_CE-1:0] nand_nce, nand_rnb = 0;
  logic nand_cle, nand_ale, nand_nwe, nand_nre, nand_nwp, nand_dq_oe;

  always #5 clk = ~clk;

  nand_phy_seq #(.NUM_CE(NUM_CE), .DW(DW), .TW(TW), .TOW(TOW)) dut (
    .clk(clk), .rst(rst),
    .cfg_twp(cfg_twp), .cfg_twh(cfg_twh), .cfg_trp(cfg_trp), .cfg_treh(cfg_treh),
    .cfg_timeout(cfg_timeout),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .op_ce(op_ce),
    .op_data(op_data), .op_last(op_last),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .wp_en(wp_en),
    .nand_nce(nand_nce), .nand_cle(nand_cle), .nand_ale(nand_ale), .nand_nwe(nand_nwe),
    .nand_nre(nand_nre), .nand_nwp(nand_nwp), .nand_dq_o(nand_dq_o),
    .nand_dq_oe(nand_dq_oe), .nand_dq_i(nand_dq_i), .nand_rnb(nand_rnb)
  );

  typedef struct {
    int typ; int ce; int data; int last;
    int twp; int twh; int trp; int treh; int dqi; int rise; int tmo;
    int exp_dur; int exp_rdk; int exp_rd;
  } vec_t;

  int checks = 0, errors = 0;
  // Reference model state: held target, sticky error, last read, WP# level.
  int m_held_vld = 0, m_held_ce = 0, m_err = 0, m_rdd = 0, m_nwp = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int mx1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic logic [27:0] snap();
    return {op_ready, nand_nce, nand_cle, nand_ale, nand_nwe, nand_nre, nand_dq_oe,
            nand_dq_o, rd_valid, rd_data, timeout_err, nand_nwp};
  endfunction

  // Issue one op and check every cycle until it should be back in IDLE.
  // Cycle k counts from the accept cycle (k=0).
  task automatic run_op(input int typ, input int ce, input int data, input int last,
                        input int twp, input int twh, input int trp, input int treh,
                        input int dqi, input int rise, input int tmo, input int clr_hold,
                        output int act_dur, output int act_rdk, output int act_rd);
    int g, dur, w1, w2, r1, r2, kr, kt, n, p;
    bit bus, tmo_hit;
    logic [1:0] nce_prev, nce_op, e_nce;
    logic e_cle, e_ale, e_nwe, e_nre, e_oe, e_rdv, e_err;
    logic [7:0] e_dq, e_rdd;
    @(negedge clk);
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_op", op_ready, 1);
    w1 = mx1(twp); w2 = mx1(twh); r1 = mx1(trp); r2 = mx1(treh);
    bus = (typ <= 4);
    g = (bus && m_held_vld != 0 && m_held_ce != ce) ? 1 : 0;
    tmo_hit = 0;
    if (typ <= 2)      dur = g + w1 + w2 + 1;
    else if (typ == 3) dur = g + r1 + r2 + 1;
    else if (typ == 4) begin
      kr = (rise < 0) ? 32'h3fffffff : ((g + 5 > rise + 2) ? g + 5 : rise + 2);
      kt = g + mx1(tmo);
      if (kr <= kt) dur = kr + 1;
      else begin dur = kt + 1; tmo_hit = 1; end
    end else dur = 1;
    nce_prev = (m_held_vld != 0) ? ~(2'b01 << m_held_ce) : 2'b11;
    nce_op   = ~(2'b01 << ce);
    cfg_twp = TW'(twp); cfg_twh = TW'(twh); cfg_trp = TW'(trp); cfg_treh = TW'(treh);
    cfg_timeout = TOW'(tmo);
    op_type = 3'(typ); op_ce = 1'(ce); op_data = 8'(data); op_last = 1'(last);
    nand_dq_i = 8'(dqi); err_clr = 1'(clr_hold);
    if (typ == 4) nand_rnb = '0;
    op_valid = 1;
    act_dur = 0; act_rdk = 0; act_rd = 0;
    for (int k = 1; k <= dur; k++) begin
      @(negedge clk);
      p = k - g;
      if (!bus)            e_nce = nce_prev;
      else if (k == dur)   e_nce = (last != 0) ? 2'b11 : nce_op;
      else if (k <= g)     e_nce = 2'b11;
      else                 e_nce = nce_op;
      e_cle = 0; e_ale = 0; e_oe = 0; e_nwe = 1; e_nre = 1; e_dq = 0; e_rdv = 0;
      if (typ <= 2 && p >= 1 && p <= w1 + w2) begin
        e_oe = 1; e_dq = 8'(data);
        e_cle = (typ == 0); e_ale = (typ == 1);
        e_nwe = !(p <= w1);
      end
      if (typ == 3) begin
        e_nre = !(p >= 1 && p <= r1);
        if (p == r1 + 1) begin e_rdv = 1; m_rdd = dqi; end
      end
      if (tmo_hit && k == dur) m_err = 1;
      else if (clr_hold != 0)  m_err = 0;
      e_rdd = 8'(m_rdd); e_err = 1'(m_err);
      chk($sformatf("op t%0d k%0d", typ, k), snap(),
          {(k == dur), e_nce, e_cle, e_ale, e_nwe, e_nre, e_oe, e_dq, e_rdv, e_rdd, e_err, 1'(m_nwp)});
      if (act_dur == 0 && op_ready) act_dur = k;
      if (act_rdk == 0 && rd_valid) begin act_rdk = k; act_rd = int'(rd_data); end
      if (k == 1) op_valid = 0;
      if (typ == 4 && rise == k) nand_rnb[ce] = 1'b1;
      if (k == dur) err_clr = 0;
    end
    if (bus) begin m_held_vld = (last == 0); m_held_ce = ce; end
  endtask

  vec_t vt[12];
  int ad, ark, ard;
  logic [4:0] exp_nwe, exp_rdy;

  initial begin
    //        typ ce data last twp twh trp treh dqi  rise tmo  dur rdk rd
    vt[0]  = '{0, 0, 'h70, 0,  2,  1,  1,  1,  0,   -1, 0,    4,  0, 0};
    vt[1]  = '{3, 0, 0,    0,  1,  1,  3,  2,  'hA5,-1, 0,    6,  4, 'hA5};
    vt[2]  = '{1, 1, 'h12, 0,  1,  1,  1,  1,  0,   -1, 0,    4,  0, 0};
    vt[3]  = '{2, 1, 'h3C, 1,  0,  0,  1,  1,  0,   -1, 0,    3,  0, 0};
    vt[4]  = '{3, 1, 0,    1,  1,  1,  0,  0,  'h5A,-1, 0,    3,  2, 'h5A};
    vt[5]  = '{5, 0, 'h99, 1,  1,  1,  1,  1,  0,   -1, 0,    1,  0, 0};
    vt[6]  = '{0, 0, 'hFF, 0,  15, 15, 1,  1,  0,   -1, 0,    31, 0, 0};
    vt[7]  = '{2, 1, 'h81, 1,  3,  2,  1,  1,  0,   -1, 0,    7,  0, 0};
    vt[8]  = '{4, 1, 0,    0,  1,  1,  1,  1,  0,   10, 100,  13, 0, 0};
    vt[9]  = '{4, 1, 0,    1,  1,  1,  1,  1,  0,   -1, 50,   51, 0, 0};
    vt[10] = '{4, 0, 0,    1,  1,  1,  1,  1,  0,   1,  20,   6,  0, 0};
    vt[11] = '{4, 0, 0,    0,  1,  1,  1,  1,  0,   -1, 3,    4,  0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", snap(), {1'b1, 2'b11, 5'b00110, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    chk("reset_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    chk("nwp_after_reset", nand_nwp, 1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].typ, vt[i].ce, vt[i].data, vt[i].last, vt[i].twp, vt[i].twh,
             vt[i].trp, vt[i].treh, vt[i].dqi, vt[i].rise, vt[i].tmo, 0, ad, ark, ard);
      chk($sformatf("vec%0d ready_cycle", i), ad, vt[i].exp_dur);
      chk($sformatf("vec%0d rd_cycle", i), ark, vt[i].exp_rdk);
      chk($sformatf("vec%0d rd_data", i), ard, (vt[i].exp_rdk != 0) ? vt[i].exp_rd : 0);
    end

    // Sticky error cleared by a one-cycle err_clr pulse
    @(negedge clk);
    chk("err_sticky", timeout_err, 1);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    m_err = 0;
    chk("err_cleared", timeout_err, 0);

    // Timeout coinciding with err_clr: the set wins
    run_op(4, 0, 0, 1, 1, 1, 1, 1, 0, -1, 5, 1, ad, ark, ard);
    chk("set_wins_ready_cycle", ad, 6);

    // cfg_twp change during WLO does not stretch the current pulse
    @(negedge clk);
    cfg_twp = 2; cfg_twh = 1;
    op_type = 0; op_ce = 0; op_data = 8'h55; op_last = 1; op_valid = 1;
    exp_nwe = 5'b11001; exp_rdy = 5'b10000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("cfgchg nwe k%0d", k), nand_nwe, exp_nwe[k]);
      chk($sformatf("cfgchg ready k%0d", k), op_ready, exp_rdy[k]);
      if (k == 1) begin op_valid = 0; cfg_twp = 6; end
    end
    m_held_vld = 0;

    // Reset asserted in the middle of WLO
    @(negedge clk);
    cfg_twp = 5; cfg_twh = 1;
    op_type = 0; op_ce = 0; op_data = 8'hC3; op_last = 0; op_valid = 1;
    @(negedge clk);
    op_valid = 0;
    @(negedge clk);
    chk("midop_nwe_low", nand_nwe, 0);
    rst = 1;
    #1;
    chk("midop_reset", {op_ready, nand_nce, nand_nwe, nand_dq_oe, nand_cle, rd_valid},
        {1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 0;
    m_held_vld = 0; m_err = 0; m_rdd = 0;
    @(negedge clk);
    chk("after_reset_ready", op_ready, 1);
    chk("after_reset_nwp", nand_nwp, 1);
    wp_en = 1;
    @(negedge clk);
    chk("wp_en_nwp", nand_nwp, 0);
    wp_en = 0;
    @(negedge clk);
    chk("wp_dis_nwp", nand_nwp, 1);

    // Randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      int rise;
      rise = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(1, 20));
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 255)), rise, int'($urandom_range(0, 30)),
             ($urandom_range(0, 5) == 0) ? 1 : 0, ad, ark, ard);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
